frame_renderer: RTL and testbench
=================================

// Module: frame_renderer
// PURPOSE
//  Downstream of the game datapath/control pair. Once per frame it snapshots game state
//  (player height, obstacle x, dead flag) and scans the 160x120 screen row-major.
//  It drives x/y/colour/plot into vga_adapter at one pixel per clock.
//  It replaces the constant writeEn=1 tie-off with a real plot strobe and signals frame completion.
// PARAMETERS
//  SCREEN_W   160  pixels per row
//  SCREEN_H   120  rows per frame
//  GROUND_Y   100  first ground row; rows GROUND_Y..SCREEN_H-1 are ground
//  PLAYER_X   20   left column of player box
//  PLAYER_W   8    player box width
//  PLAYER_H   10   player box height
//  OBST_W     6    obstacle width
//  OBST_H     12   obstacle height
// PORTS
//  clock     in   1  system clock (CLOCK_50)
//  resetn    in   1  asynchronous active-low reset
//  start     in   1  single-cycle frame request
//  player_h  in   7  player height above ground, in pixels
//  obst_x    in   8  obstacle left column; >= SCREEN_W means off-screen
//  dead      in   1  from control; selects the death colour for the player
//  x         out  8  pixel column to vga_adapter
//  y         out  7  pixel row to vga_adapter
//  colour    out  3  RGB, 1 bit per channel
//  plot      out  1  write strobe to vga_adapter
//  busy      out  1  high from start acceptance until the last pixel is plotted
//  done      out  1  one-cycle pulse after the frame completes
// BEHAVIOUR
//  - Reset (async, resetn=0): state IDLE; x=0, y=0, colour=0, plot=0, busy=0, done=0.
//  - FSM states:
//    - IDLE: on start=1, latch player_h, obst_x and dead; clear the scan counters; go to SCAN.
//    - SCAN: each cycle, register x, y and colour for the counter position, and set plot=1.
//      Column increments 0..SCREEN_W-1. At wrap, column returns to 0 and row increments.
//      After pixel (SCREEN_W-1, SCREEN_H-1), go to DONE.
//    - DONE: plot=0, busy=0, done=1 for exactly one cycle, then return to IDLE.
//  - Timing:
//    - First plot (0,0) is in the cycle after start is sampled.
//    - Frame = SCREEN_W*SCREEN_H plot cycles (19200 at defaults).
//    - done appears one cycle after the final plot.
//  - start while busy or in DONE is ignored; there is no queueing.
//  - Snapshot inputs are frozen for the whole scan; mid-frame input changes have no effect.
//  - busy=1 in the start-accept cycle's successor through the last plot cycle.
//  - Colour priority, highest first:
//    - player: 3'b010 (green), or 3'b100 (red) if the latched dead flag is set
//    - obstacle: 3'b111
//    - ground: 3'b110
//    - background: 3'b000
//  - Player box:
//    - Columns PLAYER_X..PLAYER_X+PLAYER_W-1.
//    - Rows GROUND_Y-PLAYER_H-hc .. GROUND_Y-1-hc, where hc = min(player_h, GROUND_Y-PLAYER_H).
//    - The box therefore never leaves the top of the screen.
//  - Obstacle box:
//    - Columns obst_x..obst_x+OBST_W-1, compared in 9-bit arithmetic with no wrap.
//      Columns >= SCREEN_W are clipped.
//    - Rows GROUND_Y-OBST_H..GROUND_Y-1.
//    - obst_x >= SCREEN_W draws nothing.
//  - Reset mid-scan: plot drops immediately (async); a new frame needs a fresh start.
// STRUCTURE
//  - Shared package game_pkg: colour constants (COL_BG, COL_GROUND, COL_OBST, COL_PLAYER,
//    COL_DEAD), SCREEN_W/H, GROUND_Y, and FSM state encoding.
//  - One sub-module, pixel_shader: combinational (px, py, snapshot) -> colour, with the
//    priority and box rules above.
//  - The top level holds the FSM, scan counters, snapshot registers and output registers.
// TESTING
//  1. Reset, then start with player_h=0, obst_x=200, dead=0:
//     19200 plots, in row-major order; done pulses once, at cycle 19201.
//     (20,90) is green, (0,100) is 3'b110, (0,0) is black.
//  2. player_h=127 (clamped to 90): (20,0) green; (20,9) green; (20,10) black.
//  3. obst_x=157: columns 157..159 on rows 88..99 are 3'b111; no plot has x>159.
//     obst_x=18 with player_h=0: (20,95) green (player wins priority); (18,95) 3'b111.
//  4. dead=1 at start, then dead=0 after 5 cycles: the player box stays 3'b100 for the whole frame.
//  5. start pulsed again at plot 500: ignored; total plots still 19200; a single done.
//  6. resetn low at plot 1000: plot, busy, x, y and colour go to 0 the same cycle;
//     after release, no plots until the next start.

Source files
------------

// File: rtl/game_pkg.sv
// Shared game constants: screen geometry, sprite sizes, palette, renderer FSM
// states and the per-frame snapshot record.
package game_pkg;

  localparam logic [7:0] SCREEN_W = 8'd160;
  localparam logic [6:0] SCREEN_H = 7'd120;
  localparam logic [6:0] GROUND_Y = 7'd100;
  localparam logic [7:0] PLAYER_X = 8'd20;
  localparam logic [7:0] PLAYER_W = 8'd8;
  localparam logic [6:0] PLAYER_H = 7'd10;
  localparam logic [8:0] OBST_W   = 9'd6;
  localparam logic [6:0] OBST_H   = 7'd12;

  localparam logic [7:0] X_LAST        = SCREEN_W - 8'd1;
  localparam logic [6:0] Y_LAST        = SCREEN_H - 7'd1;
  // Highest jump that still keeps the whole player box on screen.
  localparam logic [6:0] PLAYER_HC_MAX = GROUND_Y - PLAYER_H;

  localparam logic [2:0] COL_BG     = 3'b000;
  localparam logic [2:0] COL_GROUND = 3'b110;
  localparam logic [2:0] COL_OBST   = 3'b111;
  localparam logic [2:0] COL_PLAYER = 3'b010;
  localparam logic [2:0] COL_DEAD   = 3'b100;

  typedef enum logic [1:0] {
    S_IDLE,
    S_SCAN,
    S_DONE
  } state_t;

  typedef struct packed {
    logic [6:0] player_h;
    logic [7:0] obst_x;
    logic       dead;
  } snapshot_t;

endpackage

// File: rtl/frame_renderer_if.sv
// Renderer bus: frame request plus game state in, pixel stream and status out.
interface frame_renderer_if;

  logic       start;
  logic [6:0] player_h;
  logic [7:0] obst_x;
  logic       dead;
  logic [7:0] x;
  logic [6:0] y;
  logic [2:0] colour;
  logic       plot;
  logic       busy;
  logic       done;

  modport master (
    output start, player_h, obst_x, dead,
    input  x, y, colour, plot, busy, done
  );

  modport slave (
    input  start, player_h, obst_x, dead,
    output x, y, colour, plot, busy, done
  );

endinterface

// File: rtl/pixel_shader.sv
// Combinational colour lookup for one pixel given the frozen game snapshot.
module pixel_shader
  import game_pkg::*;
(
  input  logic [7:0] px,
  input  logic [6:0] py,
  input  snapshot_t  snap,
  output logic [2:0] colour
);

  logic [6:0] hc;
  logic [6:0] top;
  logic [8:0] px9;
  logic [8:0] ox9;
  logic       in_player;
  logic       in_obst;

  // Box membership tests, then fixed priority player > obstacle > ground > sky.
  always_comb begin
    hc  = (snap.player_h > PLAYER_HC_MAX) ? PLAYER_HC_MAX : snap.player_h;
    top = GROUND_Y - PLAYER_H - hc;
    px9 = {1'b0, px};
    ox9 = {1'b0, snap.obst_x};

    in_player = (px >= PLAYER_X) && (px < PLAYER_X + PLAYER_W) &&
                (py >= top) && (py < top + PLAYER_H);

    // 9-bit compare so an obstacle near the right edge does not wrap to column 0.
    in_obst = (snap.obst_x < SCREEN_W) &&
              (px9 >= ox9) && (px9 < ox9 + OBST_W) &&
              (py >= GROUND_Y - OBST_H) && (py < GROUND_Y);

    if (in_player)
      colour = snap.dead ? COL_DEAD : COL_PLAYER;
    else if (in_obst)
      colour = COL_OBST;
    else if (py >= GROUND_Y)
      colour = COL_GROUND;
    else
      colour = COL_BG;
  end

endmodule

// File: rtl/frame_renderer.sv
// Frame renderer: snapshots game state on start, then streams every pixel of
// the screen row-major at one pixel per clock, and pulses done afterwards.
module frame_renderer
  import game_pkg::*;
(
  input  logic           clock,
  input  logic           resetn,
  frame_renderer_if.slave bus
);

  state_t     state, state_nx;
  snapshot_t  snap_q, snap_in, snap_src;
  logic [7:0] x_q, x_nx;
  logic [6:0] y_q, y_nx;
  logic [2:0] colour_q, colour_nx;
  logic       plot_q, plot_nx;
  logic       busy_q, busy_nx;
  logic       done_q, done_nx;
  logic       accept;
  logic       last_px;

  assign snap_in = '{player_h: bus.player_h, obst_x: bus.obst_x, dead: bus.dead};
  assign accept  = (state == S_IDLE) && bus.start;
  assign last_px = (x_q == X_LAST) && (y_q == Y_LAST);

  // The output registers hold the pixel being plotted, so the shader looks at
  // the next position; on the accept cycle it must see the live inputs.
  assign snap_src = accept ? snap_in : snap_q;

  pixel_shader u_shader (
    .px     (x_nx),
    .py     (y_nx),
    .snap   (snap_src),
    .colour (colour_nx)
  );

  // State register.
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) state <= S_IDLE;
    else         state <= state_nx;
  end

  // Next-state logic; start outside IDLE is dropped.
  always_comb begin
    state_nx = state;
    unique case (state)
      S_IDLE:  if (bus.start) state_nx = S_SCAN;
      S_SCAN:  if (last_px)   state_nx = S_DONE;
      S_DONE:  state_nx = S_IDLE;
      default: state_nx = S_IDLE;
    endcase
  end

  // Next values for the registered outputs and scan position.
  always_comb begin
    x_nx    = x_q;
    y_nx    = y_q;
    plot_nx = 1'b0;
    busy_nx = 1'b0;
    done_nx = 1'b0;
    unique case (state)
      S_IDLE: begin
        if (bus.start) begin
          x_nx    = '0;
          y_nx    = '0;
          plot_nx = 1'b1;
          busy_nx = 1'b1;
        end
      end
      S_SCAN: begin
        if (last_px) begin
          done_nx = 1'b1;
        end else begin
          plot_nx = 1'b1;
          busy_nx = 1'b1;
          if (x_q == X_LAST) begin
            x_nx = '0;
            y_nx = y_q + 7'd1;
          end else begin
            x_nx = x_q + 8'd1;
          end
        end
      end
      default: ;
    endcase
  end

  // Snapshot capture, frozen for the rest of the frame.
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn)     snap_q <= '0;
    else if (accept) snap_q <= snap_in;
  end

  // Output registers.
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      x_q      <= '0;
      y_q      <= '0;
      colour_q <= '0;
      plot_q   <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      x_q      <= x_nx;
      y_q      <= y_nx;
      colour_q <= plot_nx ? colour_nx : COL_BG;
      plot_q   <= plot_nx;
      busy_q   <= busy_nx;
      done_q   <= done_nx;
    end
  end

  assign bus.x      = x_q;
  assign bus.y      = y_q;
  assign bus.colour = colour_q;
  assign bus.plot   = plot_q;
  assign bus.busy   = busy_q;
  assign bus.done   = done_q;

endmodule

// File: tb/tb_frame_renderer.sv
// Bench for frame_renderer: frame-level reference model, per-cycle compare,
// and literal pixel checks on captured frames.
module tb_frame_renderer;

  localparam int W    = 160;
  localparam int H    = 120;
  localparam int NPIX = W * H;

  logic clock  = 1'b0;
  logic resetn = 1'b0;

  frame_renderer_if bus();

  frame_renderer dut (
    .clock  (clock),
    .resetn (resetn),
    .bus    (bus)
  );

  always #5 clock = ~clock;

  int n_tests = 0;
  int n_fail  = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      if (n_fail <= 40)
        $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference colour straight from the box/priority rules.
  function automatic logic [2:0] ref_colour(input int px, input int py,
                                            input int ph, input int ox, input bit dd);
    int hc;
    hc = (ph > 90) ? 90 : ph;
    if (px >= 20 && px < 28 && py >= 90 - hc && py <= 99 - hc) return dd ? 3'b100 : 3'b010;
    if (ox < 160 && px >= ox && px < ox + 6 && py >= 88 && py <= 99) return 3'b111;
    if (py >= 100) return 3'b110;
    return 3'b000;
  endfunction

  // Frame-level model: 0 idle, 1 plotting pixel m_idx, 2 done pulse.
  int m_phase = 0;
  int m_idx   = 0;
  int m_ph    = 0;
  int m_ox    = 0;
  bit m_dead  = 0;
  int cyc     = 0;

  always @(posedge clock) cyc <= cyc + 1;

  always @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      m_phase <= 0;
      m_idx   <= 0;
    end else begin
      case (m_phase)
        0: if (bus.start) begin
             m_phase <= 1;
             m_idx   <= 0;
             m_ph    <= int'(bus.player_h);
             m_ox    <= int'(bus.obst_x);
             m_dead  <= bus.dead;
           end
        1: if (m_idx == NPIX - 1) m_phase <= 2;
           else                   m_idx   <= m_idx + 1;
        default: m_phase <= 0;
      endcase
    end
  end

  logic [2:0] fb [NPIX];
  int plot_cnt = 0;
  int done_cnt = 0;
  int bad_x    = 0;

  // Per-cycle compare against the model.
  always @(negedge clock) begin
    if (!resetn) begin
      chk("reset_outputs", {bus.x, bus.y, bus.colour, bus.plot, bus.busy, bus.done}, 0);
    end else begin
      chk("plot", bus.plot, m_phase == 1);
      chk("busy", bus.busy, m_phase == 1);
      chk("done", bus.done, m_phase == 2);
      if (m_phase == 1) begin
        chk("x", bus.x, m_idx % W);
        chk("y", bus.y, m_idx / W);
        chk("colour", bus.colour, ref_colour(m_idx % W, m_idx / W, m_ph, m_ox, m_dead));
        fb[m_idx] = bus.colour;
      end
      if (bus.plot) plot_cnt++;
      if (bus.done) done_cnt++;
      if (bus.plot && bus.x > 8'd159) bad_x++;
    end
  end

  function automatic logic [2:0] pix(input int px, input int py);
    return fb[py * W + px];
  endfunction

  int t_acc = 0;

  task automatic start_frame(input int ph, input int ox, input bit dd);
    plot_cnt = 0;
    done_cnt = 0;
    bad_x    = 0;
    @(negedge clock);
    bus.player_h = 7'(ph);
    bus.obst_x   = 8'(ox);
    bus.dead     = dd;
    bus.start    = 1'b1;
    @(negedge clock);
    bus.start = 1'b0;
    t_acc = cyc;
  endtask

  task automatic randomize_inputs(input bit with_start);
    bus.player_h = 7'($urandom);
    bus.obst_x   = 8'($urandom);
    bus.dead     = 1'($urandom);
    bus.start    = with_start && ($urandom_range(0, 63) == 0);
  endtask

  // Run to the done pulse (bounded), poke start during DONE, then settle.
  task automatic run_until_done(input bit noisy);
    bit got;
    got = 1'b0;
    for (int i = 0; i < NPIX + 20; i++) begin
      @(negedge clock);
      if (bus.done) begin
        got = 1'b1;
        break;
      end
      if (noisy) randomize_inputs(1'b1);
    end
    chk("done_seen", got, 1);
    if (got) chk("done_latency", cyc - t_acc + 1, NPIX + 1);
    bus.start = 1'b1;
    @(negedge clock);
    bus.start = 1'b0;
    repeat (3) @(negedge clock);
    chk("frame_plots", plot_cnt, NPIX);
    chk("frame_dones", done_cnt, 1);
    chk("frame_x_range", bad_x, 0);
  endtask

  initial begin
    int cnt;
    #20000000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int bad;
    bus.start    = 1'b0;
    bus.player_h = '0;
    bus.obst_x   = '0;
    bus.dead     = 1'b0;
    repeat (3) @(negedge clock);
    chk("rst_plot", bus.plot, 0);
    chk("rst_busy", bus.busy, 0);
    chk("rst_done", bus.done, 0);
    chk("rst_xyc", {bus.x, bus.y, bus.colour}, 0);
    resetn = 1'b1;

    // Hand-computed pins on the model itself.
    chk("model_player",  ref_colour(20, 90, 0, 200, 0), 3'b010);
    chk("model_clamp",   ref_colour(27, 9, 127, 200, 1), 3'b100);
    chk("model_obst",    ref_colour(159, 88, 0, 157, 0), 3'b111);
    chk("model_ground",  ref_colour(5, 119, 0, 200, 0), 3'b110);

    // Frame 1: defaults, noisy mid-frame inputs and an explicit start at plot 500.
    start_frame(0, 200, 0);
    repeat (499) @(negedge clock);
    bus.start = 1'b1;
    @(negedge clock);
    bus.start = 1'b0;
    run_until_done(1'b1);
    chk("f1_20_90",  pix(20, 90), 3'b010);
    chk("f1_0_100",  pix(0, 100), 3'b110);
    chk("f1_0_0",    pix(0, 0),   3'b000);
    chk("f1_27_99",  pix(27, 99), 3'b010);
    chk("f1_28_99",  pix(28, 99), 3'b000);

    // Frame 2: clamped jump plus right-edge obstacle.
    start_frame(127, 157, 0);
    run_until_done(1'b1);
    chk("f2_20_0",  pix(20, 0),  3'b010);
    chk("f2_20_9",  pix(20, 9),  3'b010);
    chk("f2_20_10", pix(20, 10), 3'b000);
    bad = 0;
    for (int yy = 88; yy <= 99; yy++)
      for (int xx = 157; xx <= 159; xx++)
        if (pix(xx, yy) !== 3'b111) bad++;
    chk("f2_obst_box", bad, 0);
    chk("f2_156_95", pix(156, 95), 3'b000);

    // Frame 3: overlap priority and dead flag frozen at start.
    start_frame(0, 18, 1);
    repeat (5) @(negedge clock);
    bus.dead = 1'b0;
    run_until_done(1'b0);
    bad = 0;
    for (int yy = 90; yy <= 99; yy++)
      for (int xx = 20; xx <= 27; xx++)
        if (pix(xx, yy) !== 3'b100) bad++;
    chk("f3_dead_box", bad, 0);
    chk("f3_20_95", pix(20, 95), 3'b100);
    chk("f3_18_95", pix(18, 95), 3'b111);
    chk("f3_19_88", pix(19, 88), 3'b111);

    // Frame 4: random snapshot, reset asserted mid-scan.
    start_frame(int'($urandom_range(0, 127)), int'($urandom_range(0, 255)), 1'($urandom));
    repeat (999) begin
      @(negedge clock);
      randomize_inputs(1'b1);
    end
    bus.start = 1'b0;
    @(posedge clock);
    #2;
    resetn = 1'b0;
    #1;
    chk("midrst_plot", bus.plot, 0);
    chk("midrst_busy", bus.busy, 0);
    chk("midrst_xyc", {bus.x, bus.y, bus.colour}, 0);
    repeat (3) @(negedge clock);
    resetn = 1'b1;
    plot_cnt = 0;
    repeat (40) begin
      @(negedge clock);
      randomize_inputs(1'b0);
    end
    chk("post_rst_plots", plot_cnt, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
